prog_loader: RTL and testbench



---
 rtl/prog_loader_pkg.sv | 21 ++
 rtl/prog_loader_ram.sv | 23 ++
 rtl/prog_loader.sv | 104 ++++++++++
 tb/tb_prog_loader.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared constants and types for the program loader: state encoding,
// the NOP instruction fed to the CPU while it is held in reset, and the debug view.
package prog_loader_pkg;

  localparam int PROG_DEPTH = 16;
  localparam int PROG_AW    = 4;
  localparam logic [7:0] NOP_INST = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2,
    ST_RUN  = 2'd3
  } ldr_state_e;

  typedef struct packed {
    ldr_state_e         state;
    logic [PROG_AW-1:0] wr_ptr;
  } ldr_dbg_t;

endpackage

// File: rtl/prog_loader_ram.sv
// Instruction store: one synchronous write port and one asynchronous read port.
// There is no reset, so contents survive a block reset.
module prog_loader_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [W-1:0]             wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [W-1:0]             rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/prog_loader.sv
// Program memory plus byte-serial loader: holds the CPU in reset while a program
// is loaded, waits HOLD_CYCLES, then serves inst = mem[pc] combinationally.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int DEPTH       = PROG_DEPTH,
  parameter int INST_W      = 8,
  parameter int HOLD_CYCLES = 5
) (
  input  logic                     clk_cpu,
  input  logic                     reset,
  input  logic [$clog2(DEPTH)-1:0] pc,
  output logic [INST_W-1:0]        inst,
  output logic                     cpu_reset,
  input  logic                     load_start,
  input  logic                     load_valid,
  input  logic [INST_W-1:0]        load_data,
  output logic                     load_ready,
  output logic                     load_done,
  output ldr_dbg_t                 dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  // Handshake: a byte transfers on a rising edge where load_valid && load_ready,
  // unless load_start is also high (restart wins and the byte is dropped).

  ldr_state_e          state_q;
  logic [AW-1:0]       wr_ptr_q;
  logic [AW-1:0]       wr_ptr_d;
  logic [HW-1:0]       hold_cnt_q;
  logic                cpu_reset_q;
  logic                load_ready_q;
  logic                load_done_q;
  logic                we;
  logic [INST_W-1:0]   ram_rdata;

  assign wr_ptr_d = wr_ptr_q + AW'(1);
  assign we       = reset && load_ready_q && load_valid && !load_start;

  always_ff @(posedge clk_cpu) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      hold_cnt_q   <= '0;
      cpu_reset_q  <= 1'b1;
      load_ready_q <= 1'b0;
      load_done_q  <= 1'b0;
    end else begin
      load_done_q <= 1'b0;
      if (load_start) begin
        state_q      <= ST_LOAD;
        wr_ptr_q     <= '0;
        cpu_reset_q  <= 1'b1;
        load_ready_q <= 1'b1;
      end else begin
        case (state_q)
          ST_LOAD: begin
            if (load_valid) begin
              wr_ptr_q <= wr_ptr_d;
              if (wr_ptr_q == AW'(DEPTH - 1)) begin
                state_q      <= ST_HOLD;
                hold_cnt_q   <= '0;
                load_ready_q <= 1'b0;
                load_done_q  <= 1'b1;
              end
            end
          end
          ST_HOLD: begin
            if (hold_cnt_q == HW'(HOLD_CYCLES - 1)) begin
              state_q     <= ST_RUN;
              cpu_reset_q <= 1'b0;
            end else begin
              hold_cnt_q <= hold_cnt_q + HW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  prog_loader_ram #(
    .DEPTH (DEPTH),
    .W     (INST_W)
  ) u_ram (
    .clk_i   (clk_cpu),
    .we_i    (we),
    .waddr_i (wr_ptr_q),
    .wdata_i (load_data),
    .raddr_i (pc),
    .rdata_o (ram_rdata)
  );

  assign inst       = (state_q == ST_RUN) ? ram_rdata : INST_W'(NOP_INST);
  assign cpu_reset  = cpu_reset_q;
  assign load_ready = load_ready_q;
  assign load_done  = load_done_q;

  assign dbg.state  = state_q;
  assign dbg.wr_ptr = PROG_AW'(wr_ptr_q);

endmodule

// File: tb/tb_prog_loader.sv
// Directed-plus-random bench for prog_loader: a plain array models program
// memory; load/hold/run timing is checked against the externally visible rules.
module tb_prog_loader;
  import prog_loader_pkg::*;

  logic       clk_cpu = 1'b0;
  logic       reset;
  logic [3:0] pc;
  logic [7:0] inst;
  logic       cpu_reset;
  logic       load_start;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic       load_done;
  ldr_dbg_t   dbg;

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_mem  [16];
  logic [7:0] next_prog[16];

  prog_loader dut (
    .clk_cpu    (clk_cpu),
    .reset      (reset),
    .pc         (pc),
    .inst       (inst),
    .cpu_reset  (cpu_reset),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .load_done  (load_done),
    .dbg        (dbg)
  );

  always #5 clk_cpu = ~clk_cpu;

  task automatic tick;
    @(posedge clk_cpu);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: consecutive bytes, 1: valid every other cycle, 2: random gaps
  task automatic load_prog(input int mode, input bit do_start, input bit valid_in_hold);
    int idx;
    int cyc;
    int gap;
    bit v;
    if (do_start) begin
      load_start = 1'b1;
      load_valid = 1'b0;
      tick();
      load_start = 1'b0;
    end
    chk("load_ready_in_load", load_ready, 1);
    chk("cpu_reset_in_load", cpu_reset, 1);
    chk("inst_nop_in_load", inst, 8'h00);
    idx = 0;
    cyc = 0;
    gap = 0;
    while (idx < 16) begin
      case (mode)
        0: v = 1'b1;
        1: v = (cyc % 2) == 0;
        default: v = (gap >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
      endcase
      gap = v ? 0 : gap + 1;
      load_valid = v;
      load_data  = v ? next_prog[idx] : 8'($urandom);
      tick();
      if (v) begin
        ref_mem[idx] = next_prog[idx];
        idx++;
      end
      cyc++;
      chk("load_done_pulse", load_done, (v && idx == 16) ? 1 : 0);
    end
    chk("load_ready_after_last", load_ready, 0);
    chk("cpu_reset_hold0", cpu_reset, 1);
    load_valid = valid_in_hold;
    load_data  = 8'($urandom);
    for (int k = 1; k < 5; k++) begin
      tick();
      load_data = 8'($urandom);
      chk("cpu_reset_hold", cpu_reset, 1);
      chk("load_done_once", load_done, 0);
      chk("load_ready_hold", load_ready, 0);
    end
    tick();
    load_valid = 1'b0;
    chk("cpu_reset_run", cpu_reset, 0);
    chk("state_run", 32'(dbg.state), 32'(ST_RUN));
  endtask

  task automatic readback;
    for (int a = 0; a < 16; a++) begin
      pc = 4'(a);
      #1;
      chk("inst_readback", inst, ref_mem[a]);
    end
  endtask

  initial begin
    reset      = 1'b0;
    pc         = 4'h0;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_data  = 8'h00;

    repeat (3) tick();
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_inst", inst, 8'h00);
    chk("rst_load_ready", load_ready, 0);
    chk("rst_load_done", load_done, 0);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_state", 32'(dbg.state), 32'(ST_IDLE));
      chk("idle_cpu_reset", cpu_reset, 1);
    end

    // Back-to-back load of 30..3F with valid held high through HOLD.
    for (int i = 0; i < 16; i++) next_prog[i] = 8'(8'h30 + i);
    load_prog(0, 1'b1, 1'b1);
    pc = 4'h3; #1; chk("pc3_inst", inst, 8'h33);
    pc = 4'hF; #1; chk("pcF_inst", inst, 8'h3F);
    readback();

    // load_valid in RUN is ignored.
    load_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      load_data = 8'($urandom);
      tick();
      chk("run_cpu_reset", cpu_reset, 0);
    end
    load_valid = 1'b0;
    readback();

    // Toggling valid, random bytes.
    for (int i = 0; i < 16; i++) next_prog[i] = 8'($urandom);
    load_prog(1, 1'b1, 1'b0);
    readback();

    // Restart with valid at byte 7.
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      load_valid = 1'b1;
      load_data  = 8'($urandom);
      ref_mem[i] = load_data;
      tick();
    end
    chk("wr_ptr_at_7", 32'(dbg.wr_ptr), 7);
    load_start = 1'b1;
    load_data  = 8'hEE;
    tick();
    load_start = 1'b0;
    load_valid = 1'b0;
    chk("restart_wr_ptr", 32'(dbg.wr_ptr), 0);
    chk("restart_state", 32'(dbg.state), 32'(ST_LOAD));
    chk("restart_no_done", load_done, 0);
    for (int i = 0; i < 16; i++) next_prog[i] = 8'(8'hA0 + i);
    load_prog(0, 1'b0, 1'b0);
    readback();

    // Reset asserted at byte 9.
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      load_valid = 1'b1;
      load_data  = 8'($urandom);
      ref_mem[i] = load_data;
      tick();
    end
    reset     = 1'b0;
    load_data = 8'($urandom);
    tick();
    reset      = 1'b1;
    load_valid = 1'b0;
    chk("midrst_state", 32'(dbg.state), 32'(ST_IDLE));
    chk("midrst_cpu_reset", cpu_reset, 1);
    chk("midrst_load_ready", load_ready, 0);
    chk("midrst_inst", inst, 8'h00);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("midrst_no_done", load_done, 0);
      chk("midrst_cpu_reset_hold", cpu_reset, 1);
    end

    // Random-gap load from IDLE.
    for (int i = 0; i < 16; i++) next_prog[i] = 8'($urandom);
    load_prog(2, 1'b1, 1'b0);
    readback();

    // Restart from RUN.
    pc = 4'($urandom);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("runrst_cpu_reset", cpu_reset, 1);
    chk("runrst_inst", inst, 8'h00);
    chk("runrst_load_ready", load_ready, 1);
    for (int i = 0; i < 16; i++) next_prog[i] = 8'($urandom);
    load_prog(2, 1'b0, 1'b1);
    pc = 4'h0; #1; chk("runrst_pc0", inst, ref_mem[0]);
    readback();

    for (int i = 0; i < 20; i++) begin
      pc = 4'($urandom_range(0, 15));
      #1;
      chk("inst_random_pc", inst, ref_mem[pc]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
